instr_fetch: RTL and testbench

Instruction fetch stage directly upstream of the instruction decoder. Holds the program counter and issues one word-aligned read at a time to instruction memory over a valid/ready request channel. Each returned 32-bit word is presented, with its PC, to the decoder on a valid/ready output. A redirect input from the branch/execute stage reloads the PC and squashes in-flight work.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_pc_gen.sv | 22 ++
 rtl/instr_fetch.sv | 157 +++++++++++++++
 tb/tb_instr_fetch.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Alignment fault checking is enabled by defining FETCH_ALIGN_CHECK_EN.
package fetch_pkg;

  localparam int unsigned INSTR_W       = 32;
  localparam logic [31:0] PC_INC        = 32'd4;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_FAULT
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_SEL_HOLD,
    PC_SEL_INC,
    PC_SEL_REDIRECT
  } pc_sel_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC selection: hold, sequential increment of the fetched PC, or redirect target.
// Redirect targets are always forced to word alignment.
module fetch_pc_gen
  import fetch_pkg::*;
(
  input  pc_sel_t     sel_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] req_pc_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_next_o
);

  always_comb begin
    pc_next_o = pc_i;
    unique case (sel_i)
      PC_SEL_INC:      pc_next_o = req_pc_i + PC_INC;
      PC_SEL_REDIRECT: pc_next_o = redirect_pc_i & PC_ALIGN_MASK;
      default:         pc_next_o = pc_i;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding imem read, redirect/flush, registered decoder output.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirects in S_FAULT instead of masking them.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  output logic               imem_req_valid_out,
  input  logic               imem_req_ready_in,
  output logic [31:0]        imem_addr_out,
  input  logic               imem_rsp_valid_in,
  input  logic [INSTR_W-1:0] imem_rsp_data_in,
  input  logic               redirect_valid_in,
  input  logic [31:0]        redirect_pc_in,
  output logic               instr_valid_out,
  input  logic               instr_ready_in,
  output logic [INSTR_W-1:0] instr_out,
  output logic [31:0]        pc_out,
  output logic               fault_out
);

  fetch_state_t       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        req_pc_q, req_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [31:0]        pc_out_q, pc_out_d;
  logic               instr_valid_q, instr_valid_d;
  pc_sel_t            pc_sel;
  logic               handshake, rsp;
  logic               bad_redirect, fault_pend;

  assign handshake = (state_q == S_REQ) && imem_req_ready_in;
  assign rsp       = imem_rsp_valid_in;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d, pend_q, pend_d;

  assign bad_redirect = redirect_valid_in && (redirect_pc_in[1:0] != 2'b00);
  assign fault_pend   = pend_q;
  assign fault_out    = fault_q;

  // pend tracks a request still in flight while parked in S_FAULT, so leaving
  // the fault can drain its response instead of taking it as a fresh one.
  always_comb begin
    fault_d = fault_q;
    pend_d  = pend_q;
    if (redirect_valid_in) fault_d = bad_redirect;
    if (bad_redirect) begin
      pend_d = handshake ||
               (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !rsp) ||
               ((state_q == S_FAULT) && pend_q && !rsp);
    end else if ((state_q != S_FAULT) || rsp || redirect_valid_in) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fault_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      fault_q <= fault_d;
      pend_q  <= pend_d;
    end
  end
`else
  assign bad_redirect = 1'b0;
  assign fault_pend   = 1'b0;
  assign fault_out    = 1'b0;
`endif

  fetch_pc_gen u_pc_gen (
    .sel_i        (pc_sel),
    .pc_i         (pc_q),
    .req_pc_i     (req_pc_q),
    .redirect_pc_i(redirect_pc_in),
    .pc_next_o    (pc_d)
  );

  always_comb begin
    state_d       = state_q;
    pc_sel        = PC_SEL_HOLD;
    req_pc_d      = req_pc_q;
    instr_d       = instr_q;
    pc_out_d      = pc_out_q;
    instr_valid_d = instr_valid_q;
    if (redirect_valid_in) begin
      instr_valid_d = 1'b0;
      if (bad_redirect) begin
        state_d = S_FAULT;
      end else begin
        pc_sel = PC_SEL_REDIRECT;
        // Any request already accepted must have its response drained.
        unique case (state_q)
          S_REQ:           state_d = handshake ? S_DRAIN : S_REQ;
          S_WAIT, S_DRAIN: state_d = rsp ? S_REQ : S_DRAIN;
          S_FAULT:         state_d = (fault_pend && !rsp) ? S_DRAIN : S_REQ;
          default:         state_d = S_REQ;
        endcase
      end
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (handshake) begin
            state_d  = S_WAIT;
            req_pc_d = pc_q;
          end
        end
        S_WAIT: begin
          if (rsp) begin
            state_d       = S_HOLD;
            instr_d       = imem_rsp_data_in;
            pc_out_d      = req_pc_q;
            instr_valid_d = 1'b1;
            pc_sel        = PC_SEL_INC;
          end
        end
        S_HOLD: begin
          if (instr_ready_in) begin
            state_d       = S_REQ;
            instr_valid_d = 1'b0;
          end
        end
        S_DRAIN: if (rsp) state_d = S_REQ;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      req_pc_q      <= RESET_PC;
      instr_q       <= NOP_INSTR;
      pc_out_q      <= RESET_PC;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      instr_q       <= instr_d;
      pc_out_q      <= pc_out_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req_valid_out = (state_q == S_REQ);
  assign imem_addr_out      = pc_q;
  assign instr_valid_out    = instr_valid_q;
  assign instr_out          = instr_q;
  assign pc_out             = pc_out_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Cycle-by-cycle directed vectors for instr_fetch, plus an async-reset sequence.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, rsp_valid, redir_valid, instr_valid, instr_ready, fault;
  logic [31:0] addr, rsp_data, redir_pc, instr, pc;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk_in            (clk),
    .rst_n_in          (rst_n),
    .imem_req_valid_out(req_valid),
    .imem_req_ready_in (req_ready),
    .imem_addr_out     (addr),
    .imem_rsp_valid_in (rsp_valid),
    .imem_rsp_data_in  (rsp_data),
    .redirect_valid_in (redir_valid),
    .redirect_pc_in    (redir_pc),
    .instr_valid_out   (instr_valid),
    .instr_ready_in    (instr_ready),
    .instr_out         (instr),
    .pc_out            (pc),
    .fault_out         (fault)
  );

  // One record per cycle: inputs driven during the cycle, outputs expected during it.
  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        ir;
    logic        mr;
    logic        rspv;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_fault;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic rv, input logic [31:0] rpc, input logic ir, input logic mr,
                     input logic rspv, input logic [31:0] rdata, input logic e_req,
                     input logic [31:0] e_addr, input logic e_iv, input logic [31:0] e_instr,
                     input logic [31:0] e_pc, input logic e_fault);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.ir = ir; v.mr = mr; v.rspv = rspv; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_instr = e_instr;
    v.e_pc = e_pc; v.e_fault = e_fault;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic e_req, input logic [31:0] e_addr,
                       input logic e_iv, input logic [31:0] e_instr, input logic [31:0] e_pc,
                       input logic e_fault);
    n_vec++;
    if ({req_valid, addr, instr_valid, instr, pc, fault} !==
        {e_req, e_addr, e_iv, e_instr, e_pc, e_fault}) begin
      n_bad++;
      $display("FAIL %s: got req=%b addr=%h iv=%b instr=%h pc=%h fault=%b, want req=%b addr=%h iv=%b instr=%h pc=%h fault=%b",
               name, req_valid, addr, instr_valid, instr, pc, fault,
               e_req, e_addr, e_iv, e_instr, e_pc, e_fault);
    end
  endtask

  initial begin
    //  rv  rpc            ir  mr  rsp data           | req addr           iv instr          pc             flt
    // Sequential fetch 0, 4, 8 at 3 cycles per instruction.
    add(0, 32'h0,          1,  1,  0, 32'h0,          0, 32'h0,          0, 32'h13,        32'h0,         0);
    add(0, 32'h0,          1,  1,  0, 32'h0,          1, 32'h0,          0, 32'h13,        32'h0,         0);
    add(0, 32'h0,          1,  1,  1, 32'h3,          0, 32'h0,          0, 32'h13,        32'h0,         0);
    add(0, 32'h0,          1,  1,  0, 32'h0,          0, 32'h4,          1, 32'h3,         32'h0,         0);
    add(0, 32'h0,          1,  1,  0, 32'h0,          1, 32'h4,          0, 32'h3,         32'h0,         0);
    add(0, 32'h0,          1,  1,  1, 32'h23,         0, 32'h4,          0, 32'h3,         32'h0,         0);
    add(0, 32'h0,          1,  1,  0, 32'h0,          0, 32'h8,          1, 32'h23,        32'h4,         0);
    add(0, 32'h0,          1,  1,  0, 32'h0,          1, 32'h8,          0, 32'h23,        32'h4,         0);
    add(0, 32'h0,          1,  1,  1, 32'h43,         0, 32'h8,          0, 32'h23,        32'h4,         0);
    // Decoder stalls 5 cycles in S_HOLD.
    for (int k = 0; k < 5; k++)
      add(0, 32'h0,        0,  1,  0, 32'h0,          0, 32'hC,          1, 32'h43,        32'h8,         0);
    add(0, 32'h0,          1,  1,  0, 32'h0,          0, 32'hC,          1, 32'h43,        32'h8,         0);
    // Memory not ready for one cycle.
    add(0, 32'h0,          1,  0,  0, 32'h0,          1, 32'hC,          0, 32'h43,        32'h8,         0);
    add(0, 32'h0,          1,  1,  0, 32'h0,          1, 32'hC,          0, 32'h43,        32'h8,         0);
    // Redirect in S_WAIT: stale response dropped, fetch at 0x100.
    add(1, 32'h100,        1,  1,  0, 32'h0,          0, 32'hC,          0, 32'h43,        32'h8,         0);
    add(0, 32'h0,          1,  1,  1, 32'hDEAD,       0, 32'h100,        0, 32'h43,        32'h8,         0);
    add(0, 32'h0,          1,  1,  0, 32'h0,          1, 32'h100,        0, 32'h43,        32'h8,         0);
    add(0, 32'h0,          1,  1,  1, 32'h803,        0, 32'h100,        0, 32'h43,        32'h8,         0);
    add(0, 32'h0,          1,  1,  0, 32'h0,          0, 32'h104,        1, 32'h803,       32'h100,       0);
    add(0, 32'h0,          1,  1,  0, 32'h0,          1, 32'h104,        0, 32'h803,       32'h100,       0);
    // Redirect coincident with response, then with request handshake.
    add(1, 32'h200,        1,  1,  1, 32'hBAD,        0, 32'h104,        0, 32'h803,       32'h100,       0);
    add(1, 32'h300,        1,  1,  0, 32'h0,          1, 32'h200,        0, 32'h803,       32'h100,       0);
    add(0, 32'h0,          1,  1,  0, 32'h0,          0, 32'h300,        0, 32'h803,       32'h100,       0);
    add(0, 32'h0,          1,  1,  1, 32'hBAD,        0, 32'h300,        0, 32'h803,       32'h100,       0);
    add(0, 32'h0,          1,  1,  0, 32'h0,          1, 32'h300,        0, 32'h803,       32'h100,       0);
    add(0, 32'h0,          1,  1,  1, 32'h1803,       0, 32'h300,        0, 32'h803,       32'h100,       0);
    // Redirect with consume in S_HOLD, to the top word; PC wraps to 0.
    add(1, 32'hFFFF_FFFC,  1,  1,  0, 32'h0,          0, 32'h304,        1, 32'h1803,      32'h300,       0);
    add(0, 32'h0,          1,  1,  0, 32'h0,          1, 32'hFFFF_FFFC,  0, 32'h1803,      32'h300,       0);
    add(0, 32'h0,          1,  1,  1, 32'h77,         0, 32'hFFFF_FFFC,  0, 32'h1803,      32'h300,       0);
    add(0, 32'h0,          1,  1,  0, 32'h0,          0, 32'h0,          1, 32'h77,        32'hFFFF_FFFC, 0);
    // Misaligned redirect to 0x102, then aligned redirect to 0x200.
    add(1, 32'h102,        1,  0,  0, 32'h0,          1, 32'h0,          0, 32'h77,        32'hFFFF_FFFC, 0);
`ifdef FETCH_ALIGN_CHECK_EN
    add(0, 32'h0,          1,  0,  0, 32'h0,          0, 32'h0,          0, 32'h77,        32'hFFFF_FFFC, 1);
    add(1, 32'h200,        1,  0,  0, 32'h0,          0, 32'h0,          0, 32'h77,        32'hFFFF_FFFC, 1);
`else
    add(0, 32'h0,          1,  0,  0, 32'h0,          1, 32'h100,        0, 32'h77,        32'hFFFF_FFFC, 0);
    add(1, 32'h200,        1,  0,  0, 32'h0,          1, 32'h100,        0, 32'h77,        32'hFFFF_FFFC, 0);
`endif
    add(0, 32'h0,          1,  1,  0, 32'h0,          1, 32'h200,        0, 32'h77,        32'hFFFF_FFFC, 0);
    add(0, 32'h0,          1,  1,  1, 32'h2003,       0, 32'h200,        0, 32'h77,        32'hFFFF_FFFC, 0);
    add(0, 32'h0,          0,  1,  0, 32'h0,          0, 32'h204,        1, 32'h2003,      32'h200,       0);

    redir_valid = 1'b0; redir_pc = '0; instr_ready = 1'b0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      check($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_iv,
            vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_fault);
      redir_valid = vecs[i].rv;
      redir_pc    = vecs[i].rpc;
      instr_ready = vecs[i].ir;
      req_ready   = vecs[i].mr;
      rsp_valid   = vecs[i].rspv;
      rsp_data    = vecs[i].rdata;
      @(negedge clk);
    end

    // Asynchronous reset while holding an instruction, then restart.
    redir_valid = 1'b0; instr_ready = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_reset", 0, 32'h0, 0, 32'h13, 32'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("restart_req", 1, 32'h0, 0, 32'h13, 32'h0, 0);
    @(posedge clk);
    #1;
    check("restart_hold_req", 1, 32'h0, 0, 32'h13, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
